// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like bus between the inst-fetch and data ports. Grants are held until
// address accept. An in-order owner FIFO steers each data return back to its requester.
module sram_like_arbiter #(
  parameter int DEPTH = 2,
  parameter int RR    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        err_spurious
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          lock_valid_q, lock_valid_d;
  logic          lock_owner_q, lock_owner_d;
  logic          last_owner_q, last_owner_d;
  logic          err_spurious_q, err_spurious_d;

  logic owner;      // 0 = inst, 1 = data
  logic owner_req;
  logic empty, full;
  logic head;
  logic push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = fifo_q[rd_ptr_q];

  // A pending lock pins the owner so the downstream sees a stable address.
  always_comb begin
    owner = 1'b0;
    if (lock_valid_q) begin
      owner = lock_owner_q;
    end else if (RR == 0) begin
      owner = data_req;
    end else if (inst_req && data_req) begin
      owner = ~last_owner_q;
    end else begin
      owner = data_req;
    end
  end

  assign owner_req = owner ? data_req : inst_req;
  assign m_req     = owner_req & ~full & ~rst;
  assign m_wr      = owner ? data_wr    : inst_wr;
  assign m_size    = owner ? data_size  : inst_size;
  assign m_addr    = owner ? data_addr  : inst_addr;
  assign m_wdata   = owner ? data_wdata : inst_wdata;

  assign push = m_req & m_addr_ok;
  assign pop  = m_data_ok & ~empty & ~rst;

  assign inst_addr_ok = push & ~owner;
  assign data_addr_ok = push & owner;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign busy         = ~empty;
  assign err_spurious = err_spurious_q;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    lock_valid_d   = lock_valid_q;
    lock_owner_d   = lock_owner_q;
    last_owner_d   = last_owner_q;
    err_spurious_d = err_spurious_q | (m_data_ok & empty);

    if (push) begin
      wr_ptr_d     = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      last_owner_d = owner;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A dropped request while locked keeps the lock; only an address accept releases it.
    if (m_req && !m_addr_ok) begin
      lock_valid_d = 1'b1;
      lock_owner_d = owner;
    end else if (m_addr_ok) begin
      lock_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      lock_valid_q   <= 1'b0;
      lock_owner_q   <= 1'b0;
      last_owner_q   <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      lock_valid_q   <= lock_valid_d;
      lock_owner_q   <= lock_owner_d;
      last_owner_q   <= last_owner_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  // Owner storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= owner;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: one fixed-priority and one round-robin instance
// share the same stimulus; each is checked against hand-computed expectations.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  logic        a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok;
  logic [31:0] a_inst_rdata, a_data_rdata, a_m_addr, a_m_wdata;
  logic        a_m_req, a_m_wr, a_busy, a_err;
  logic [1:0]  a_m_size;
  logic        b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok;
  logic [31:0] b_inst_rdata, b_data_rdata, b_m_addr, b_m_wdata;
  logic        b_m_req, b_m_wr, b_busy, b_err;
  logic [1:0]  b_m_size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.DEPTH(2), .RR(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(a_inst_addr_ok), .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
    .m_req(a_m_req), .m_wr(a_m_wr), .m_size(a_m_size), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(a_busy), .err_spurious(a_err)
  );

  sram_like_arbiter #(.DEPTH(2), .RR(1)) dut_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(b_inst_addr_ok), .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(b_data_addr_ok), .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
    .m_req(b_m_req), .m_wr(b_m_wr), .m_size(b_m_size), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(b_busy), .err_spurious(b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset: no request or handshake may escape while rst is high.
    inst_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
    #1;
    check("rst_m_req",     a_m_req, 1'b0);
    check("rst_addr_ok",   a_inst_addr_ok, 1'b0);
    check("rst_data_ok",   a_inst_data_ok | a_data_data_ok, 1'b0);
    tick();
    rst = 1'b0; idle_inputs();
    #1;
    check("rst_busy",      a_busy, 1'b0);
    check("rst_err",       a_err, 1'b0);
    check("rst_m_req_idle", a_m_req, 1'b0);

    // Single inst read.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1'b1;
    #1;
    check("rd_m_req",      a_m_req, 1'b1);
    check("rd_m_addr",     a_m_addr, 32'hBFC0_0000);
    check("rd_m_size",     a_m_size, 2'd2);
    check("rd_inst_aok",   a_inst_addr_ok, 1'b1);
    check("rd_data_aok",   a_data_addr_ok, 1'b0);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    #1;
    check("rd_busy_c1",    a_busy, 1'b1);
    check("rd_nodok_c1",   a_inst_data_ok, 1'b0);
    tick();
    m_data_ok = 1'b1; m_rdata = 32'h3C08_0001;
    #1;
    check("rd_inst_dok",   a_inst_data_ok, 1'b1);
    check("rd_inst_rdata", a_inst_rdata, 32'h3C08_0001);
    check("rd_data_dok",   a_data_data_ok, 1'b0);
    check("rd_busy_c2",    a_busy, 1'b1);
    check("rd_rr_rdata",   b_inst_rdata, 32'h3C08_0001);
    tick();
    m_data_ok = 1'b0;
    #1;
    check("rd_busy_c3",    a_busy, 1'b0);

    // Lock hold: data write stalled by the bus while inst rises.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
    data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    #1;
    check("lk_addr_c0",    a_m_addr, 32'h8000_0010);
    check("lk_wdata_c0",   a_m_wdata, 32'hDEAD_BEEF);
    check("lk_size_c0",    a_m_size, 2'd1);
    tick();
    for (int c = 1; c < 3; c++) begin
      inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
      #1;
      check("lk_addr_hold",  a_m_addr, 32'h8000_0010);
      check("lk_wr_hold",    a_m_wr, 1'b1);
      check("lk_rr_addr",    b_m_addr, 32'h8000_0010);
      check("lk_inst_aok",   a_inst_addr_ok | b_inst_addr_ok, 1'b0);
      tick();
    end
    m_addr_ok = 1'b1;
    #1;
    check("lk_data_aok",   a_data_addr_ok, 1'b1);
    check("lk_inst_aok3",  a_inst_addr_ok, 1'b0);
    tick();
    data_req = 1'b0; data_wr = 1'b0;
    #1;
    check("lk_inst_grant", a_inst_addr_ok, 1'b1);
    check("lk_inst_addr",  a_m_addr, 32'hBFC0_0004);
    check("lk_inst_wr",    a_m_wr, 1'b0);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0000_00AA;
    #1;
    check("lk_ret0_data",  a_data_data_ok, 1'b1);
    check("lk_ret0_inst",  a_inst_data_ok, 1'b0);
    check("lk_ret0_rdata", a_data_rdata, 32'h0000_00AA);
    tick();
    m_rdata = 32'h0000_00BB;
    #1;
    check("lk_ret1_inst",  a_inst_data_ok, 1'b1);
    check("lk_ret1_rr",    b_inst_data_ok, 1'b1);
    tick();
    m_data_ok = 1'b0;
    #1;
    check("lk_idle_busy",  a_busy, 1'b0);

    // Lock against priority: inst stalled first must keep the bus when data rises.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    #1;
    check("lk2_addr_c0",   a_m_addr, 32'hBFC0_0008);
    tick();
    data_req = 1'b1; data_addr = 32'h8000_0020; data_wr = 1'b0; data_wdata = 32'h0;
    #1;
    check("lk2_addr_c1",   a_m_addr, 32'hBFC0_0008);
    check("lk2_data_aok",  a_data_addr_ok, 1'b0);
    tick();
    m_addr_ok = 1'b1;
    #1;
    check("lk2_inst_aok",  a_inst_addr_ok, 1'b1);
    check("lk2_addr_c2",   a_m_addr, 32'hBFC0_0008);
    tick();
    inst_req = 1'b0;
    #1;
    check("lk2_data_aok3", a_data_addr_ok, 1'b1);
    check("lk2_addr_c3",   a_m_addr, 32'h8000_0020);
    tick();

    // Full: third request blocked, then released by a return.
    data_addr = 32'h8000_0030;
    #1;
    check("full_m_req",    a_m_req, 1'b0);
    check("full_rr_m_req", b_m_req, 1'b0);
    check("full_data_aok", a_data_addr_ok, 1'b0);
    tick();
    m_data_ok = 1'b1; m_rdata = 32'h0000_0011;
    #1;
    check("full_ret_inst", a_inst_data_ok, 1'b1);
    check("full_ret_rd",   a_inst_rdata, 32'h0000_0011);
    check("full_m_req2",   a_m_req, 1'b0);
    tick();
    // Simultaneous push (inst) and pop (data) at count 1.
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_000C; m_rdata = 32'h0000_0022;
    #1;
    check("pp_inst_aok",   a_inst_addr_ok, 1'b1);
    check("pp_data_dok",   a_data_data_ok, 1'b1);
    check("pp_inst_dok",   a_inst_data_ok, 1'b0);
    check("pp_rdata",      a_data_rdata, 32'h0000_0022);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0; m_rdata = 32'h0000_0033;
    #1;
    check("pp_busy",       a_busy, 1'b1);
    check("pp_inst_dok2",  a_inst_data_ok, 1'b1);
    check("pp_data_dok2",  a_data_data_ok, 1'b0);
    tick();
    m_data_ok = 1'b0;
    #1;
    check("pp_empty",      a_busy, 1'b0);

    // Priority: both ports request continuously, one return per cycle from cycle 1.
    reset_dut();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    data_req = 1'b1; data_addr = 32'h8000_0100;
    m_addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      m_data_ok = (c != 0); m_rdata = 32'h100 + 32'(c);
      #1;
      check("pri_fix_data",  a_data_addr_ok, 1'b1);
      check("pri_fix_inst",  a_inst_addr_ok, 1'b0);
      check("pri_rr_data",   b_data_addr_ok, (c % 2 == 0) ? 1'b1 : 1'b0);
      check("pri_rr_inst",   b_inst_addr_ok, (c % 2 == 1) ? 1'b1 : 1'b0);
      check("pri_rr_addr",   b_m_addr, (c % 2 == 0) ? 32'h8000_0100 : 32'hBFC0_0100);
      if (c != 0) begin
        check("pri_fix_dok",   a_data_data_ok, 1'b1);
        check("pri_rr_ddok",   b_data_data_ok, (c % 2 == 1) ? 1'b1 : 1'b0);
        check("pri_rr_idok",   b_inst_data_ok, (c % 2 == 0) ? 1'b1 : 1'b0);
      end
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    #1;
    check("pri_last_fix",  a_data_data_ok, 1'b1);
    check("pri_last_rr",   b_inst_data_ok, 1'b1);
    tick();
    m_data_ok = 1'b0;
    #1;
    check("pri_busy",      a_busy | b_busy, 1'b0);

    // Spurious return, then reset with two outstanding.
    m_data_ok = 1'b1;
    #1;
    check("sp_no_dok",     a_inst_data_ok | a_data_data_ok, 1'b0);
    tick();
    m_data_ok = 1'b0;
    #1;
    check("sp_err",        a_err, 1'b1);
    check("sp_busy",       a_busy, 1'b0);
    inst_req = 1'b1; m_addr_ok = 1'b1;
    tick();
    tick();
    #1;
    check("rs_busy_pre",   a_busy, 1'b1);
    rst = 1'b1; m_data_ok = 1'b1;
    #1;
    check("rs_m_req",      a_m_req, 1'b0);
    check("rs_aok",        a_inst_addr_ok, 1'b0);
    check("rs_dok",        a_inst_data_ok, 1'b0);
    tick();
    rst = 1'b0; idle_inputs();
    #1;
    check("rs_busy",       a_busy, 1'b0);
    check("rs_err",        a_err, 1'b0);
    check("rs_rr_busy",    b_busy, 1'b0);
    m_data_ok = 1'b1;
    #1;
    check("rs_late_dok",   a_inst_data_ok | a_data_data_ok, 1'b0);
    tick();
    m_data_ok = 1'b0;
    #1;
    check("rs_late_err",   a_err, 1'b1);
    check("rs_rr_err",     b_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
